// File: rtl/cam_ctrl_pkg.sv
// cam_ctrl_pkg: shared definitions for the CAM access controller.
//   - default geometry (key width, slot index width, reserved scrub key)
//   - request op encoding
//   - controller state enum
//   - response record returned to the requesters
package cam_ctrl_pkg;

  localparam int unsigned DEF_KEY_W  = 8;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam logic [DEF_KEY_W-1:0] DEF_RESERVED_KEY = 8'hFF;

  localparam logic OP_LOOKUP = 1'b0;
  localparam logic OP_INSERT = 1'b1;

  typedef enum logic [2:0] {
    ST_SCRUB,
    ST_IDLE,
    ST_LOOKUP,
    ST_CAPTURE,
    ST_WRITE,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic                  id;
    logic [DEF_ADDR_W-1:0] addr;
    logic                  hit;
    logic                  err;
  } rsp_t;

endpackage

// File: rtl/cam_slot_alloc.sv
// cam_slot_alloc: slot bookkeeping for the CAM.
//   Holds the per-slot valid bitmap, picks the lowest free slot (or the
//   round-robin victim once every slot is valid) and reports full.
// Ports:
//   clk          rising-edge clock
//   clear        synchronous clear of bitmap and victim pointer
//   alloc        mark `slot` valid this cycle (advances victim when full)
//   query_addr   slot whose validity is reported on query_valid
//   slot         slot the next write will use
//   full         all slots valid
//   query_valid  valid bit of query_addr
module cam_slot_alloc
  import cam_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              alloc,
  input  logic [ADDR_W-1:0] query_addr,
  output logic [ADDR_W-1:0] slot,
  output logic              full,
  output logic              query_valid
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W-1:0] victim_q;
  logic [ADDR_W-1:0] free_idx;
  logic              free_found;

  // Lowest-index free slot.
  always_comb begin
    free_idx   = '0;
    free_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!free_found && !valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = i[ADDR_W-1:0];
      end
    end
  end

  assign full        = &valid_q;
  assign slot        = full ? victim_q : free_idx;
  assign query_valid = valid_q[query_addr];

  always_ff @(posedge clk) begin
    if (clear) begin
      valid_q  <= '0;
      victim_q <= '0;
    end else if (alloc) begin
      valid_q[slot] <= 1'b1;
      if (full) victim_q <= victim_q + 1'b1;
    end
  end

endmodule

// File: rtl/cam_access_ctrl.sv
// cam_access_ctrl: shares a 16x8 CAM between requesters A and B.
//   Round-robin arbitration of lookup/insert requests, CAM strobe
//   sequencing, slot allocation and one response per accepted request.
//   After reset every slot is scrubbed with RESERVED_KEY.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   a_/b_valid, _op, _key        requests (op 0 = lookup, 1 = insert)
//   a_/b_ready                   request accepted this cycle
//   rsp_valid/ready              response handshake
//   rsp_id/addr/hit/err          response fields (id 0 = A, 1 = B)
//   full                         every slot valid
//   cam_wen/ren/din/addr         CAM strobe port (never both strobes high)
//   cam_dout/cam_hit             CAM registered match result
// Build option: CAM_DUP_CHECK_EN makes inserts look the key up first and
// skip the write when it is already present.
module cam_access_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int unsigned KEY_W  = DEF_KEY_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter logic [KEY_W-1:0] RESERVED_KEY = DEF_RESERVED_KEY
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic              a_op,
  input  logic [KEY_W-1:0]  a_key,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic              b_op,
  input  logic [KEY_W-1:0]  b_key,
  output logic              b_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_hit,
  output logic              rsp_err,
  output logic              full,
  output logic              cam_wen,
  output logic              cam_ren,
  output logic [KEY_W-1:0]  cam_din,
  output logic [ADDR_W-1:0] cam_addr,
  input  logic [ADDR_W-1:0] cam_dout,
  input  logic              cam_hit
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] scrub_q;
  logic              rr_q;        // 1: B wins the next contested grant
  logic [KEY_W-1:0]  key_q;
  logic              id_q;
  rsp_t              rsp_q;
`ifdef CAM_DUP_CHECK_EN
  logic              op_q;
`endif

  logic              any_req;
  logic              sel_b;
  logic              sel_op;
  logic [KEY_W-1:0]  sel_key;
  logic              alloc;
  logic [ADDR_W-1:0] slot;
  logic              query_valid;
  logic              qual_hit;

  assign any_req = a_valid | b_valid;
  assign sel_b   = b_valid & (~a_valid | rr_q);
  assign sel_op  = sel_b ? b_op  : a_op;
  assign sel_key = sel_b ? b_key : a_key;
  // A CAM hit only counts if the slot has been written since the scrub.
  assign qual_hit = cam_hit & query_valid;

  cam_slot_alloc #(.ADDR_W(ADDR_W)) u_slot_alloc (
    .clk         (clk),
    .clear       (rst),
    .alloc       (alloc),
    .query_addr  (cam_dout),
    .slot        (slot),
    .full        (full),
    .query_valid (query_valid)
  );

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = rsp_q.id;
  assign rsp_addr  = rsp_q.addr;
  assign rsp_hit   = rsp_q.hit;
  assign rsp_err   = rsp_q.err;

  always_comb begin
    state_d  = state_q;
    a_ready  = 1'b0;
    b_ready  = 1'b0;
    cam_wen  = 1'b0;
    cam_ren  = 1'b0;
    cam_din  = key_q;
    cam_addr = '0;
    alloc    = 1'b0;
    case (state_q)
      ST_SCRUB: begin
        cam_wen  = 1'b1;
        cam_din  = RESERVED_KEY;
        cam_addr = scrub_q;
        if (scrub_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (any_req) begin
          a_ready = ~sel_b;
          b_ready = sel_b;
          if (sel_key == RESERVED_KEY) begin
            state_d = ST_RESP;
          end else if (sel_op == OP_INSERT) begin
`ifdef CAM_DUP_CHECK_EN
            state_d = ST_LOOKUP;
`else
            state_d = ST_WRITE;
`endif
          end else begin
            state_d = ST_LOOKUP;
          end
        end
      end
      ST_LOOKUP: begin
        cam_ren = 1'b1;
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
`ifdef CAM_DUP_CHECK_EN
        state_d = (op_q == OP_INSERT && !qual_hit) ? ST_WRITE : ST_RESP;
`else
        state_d = ST_RESP;
`endif
      end
      ST_WRITE: begin
        cam_wen  = 1'b1;
        cam_addr = slot;
        alloc    = 1'b1;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_SCRUB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_SCRUB;
      scrub_q <= '0;
      rr_q    <= 1'b0;
      key_q   <= '0;
      id_q    <= 1'b0;
      rsp_q   <= '0;
`ifdef CAM_DUP_CHECK_EN
      op_q    <= OP_LOOKUP;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_SCRUB: scrub_q <= scrub_q + 1'b1;
        ST_IDLE: begin
          if (any_req) begin
            key_q <= sel_key;
            id_q  <= sel_b;
`ifdef CAM_DUP_CHECK_EN
            op_q  <= sel_op;
`endif
            if (a_valid && b_valid) rr_q <= ~sel_b;
            if (sel_key == RESERVED_KEY)
              rsp_q <= '{id: sel_b, addr: '0, hit: 1'b0, err: 1'b1};
          end
        end
        ST_CAPTURE: rsp_q <= '{id: id_q, addr: cam_dout, hit: qual_hit, err: 1'b0};
        ST_WRITE:   rsp_q <= '{id: id_q, addr: slot, hit: 1'b0, err: 1'b0};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cam_access_ctrl.sv
// tb_cam_access_ctrl: scoreboard bench for cam_access_ctrl with a
// behavioural CAM attached and a slot-table reference model.
module tb_cam_access_ctrl;

`ifdef CAM_DUP_CHECK_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  logic       clk = 1'b0, rst = 1'b1;
  logic       a_valid = 1'b0, a_op = 1'b0, b_valid = 1'b0, b_op = 1'b0;
  logic [7:0] a_key = '0, b_key = '0;
  logic       a_ready, b_ready, rsp_valid, rsp_id, rsp_hit, rsp_err, full;
  logic       rsp_ready = 1'b1;
  logic       cam_wen, cam_ren;
  logic [3:0] rsp_addr, cam_addr;
  logic [7:0] cam_din;
  logic [3:0] cam_dout = '0;
  logic       cam_hit = 1'b0;

  cam_access_ctrl #(.KEY_W(8), .ADDR_W(4), .RESERVED_KEY(8'hFF)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_op(a_op), .a_key(a_key), .a_ready(a_ready),
    .b_valid(b_valid), .b_op(b_op), .b_key(b_key), .b_ready(b_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_addr(rsp_addr), .rsp_hit(rsp_hit), .rsp_err(rsp_err), .full(full),
    .cam_wen(cam_wen), .cam_ren(cam_ren), .cam_din(cam_din),
    .cam_addr(cam_addr), .cam_dout(cam_dout), .cam_hit(cam_hit)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  initial forever begin @(posedge clk); cyc++; end

  // Behavioural CAM: registered match, highest matching index wins.
  logic [7:0] cmem [16];
  always @(posedge clk) begin
    if (cam_wen) cmem[cam_addr] <= cam_din;
    if (cam_ren) begin
      cam_hit  <= 1'b0;
      cam_dout <= '0;
      for (int i = 0; i < 16; i++)
        if (cmem[i] == cam_din) begin cam_hit <= 1'b1; cam_dout <= 4'(i); end
    end
  end

  int total = 0, bad = 0;
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
    end
  endtask

  // Reference model: slot table, victim pointer, arbitration pointer.
  typedef struct {
    logic id; logic [3:0] addr; logic hit; logic err;
    int lat; int nwen; int nren; int gcyc;
  } exp_t;
  exp_t expq[$];
  logic [7:0] m_key [16];
  bit         m_valid [16];
  int         m_victim = 0;
  bit         m_rr = 0;

  function automatic bit m_full();
    for (int i = 0; i < 16; i++) if (!m_valid[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic predict(input bit id, input bit op, input logic [7:0] key);
    exp_t e;
    int idx;
    int slot;
    e.id = id; e.addr = '0; e.hit = 1'b0; e.err = 1'b0;
    e.nwen = 0; e.nren = 0; e.gcyc = cyc; e.lat = 0;
    idx = -1;
    for (int i = 0; i < 16; i++) if (m_valid[i] && m_key[i] == key) idx = i;
    if (key == 8'hFF) begin
      e.err = 1'b1; e.lat = 1;
    end else if (op == 1'b0 || (DUP && idx >= 0)) begin
      e.lat = 3; e.nren = 1;
      if (idx >= 0) begin e.hit = 1'b1; e.addr = 4'(idx); end
    end else begin
      slot = -1;
      for (int i = 0; i < 16; i++) if (!m_valid[i] && slot < 0) slot = i;
      if (slot < 0) begin slot = m_victim; m_victim = (m_victim + 1) % 16; end
      m_valid[slot] = 1'b1;
      m_key[slot]   = key;
      e.addr = 4'(slot);
      e.lat  = DUP ? 4 : 2;
      e.nwen = 1;
      e.nren = DUP ? 1 : 0;
    end
    expq.push_back(e);
  endtask

  // Response ready driver: 0 = always ready, 1 = random, 2 = held low.
  int rdy_mode = 0;
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = ($urandom_range(0, 3) != 0);
      default: rsp_ready = 1'b0;
    endcase
  end

  // Monitor: strobe accounting and response comparison.
  exp_t mon_e;
  int   wen_cnt = 0, ren_cnt = 0;
  bit   first_seen = 0;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      first_seen = 0; wen_cnt = 0; ren_cnt = 0;
    end else begin
      check("strobe_excl", {31'b0, cam_wen & cam_ren}, 0);
      if (a_ready || b_ready) begin
        wen_cnt = 0; ren_cnt = 0;
      end else begin
        if (cam_wen) wen_cnt++;
        if (cam_ren) ren_cnt++;
      end
      if (rsp_valid) begin
        check("no_grant_in_resp", {31'b0, a_ready | b_ready}, 0);
        check("rsp_expected", {31'b0, expq.size() > 0}, 1);
        if (expq.size() > 0) begin
          mon_e = expq[0];
          if (!first_seen) begin
            check("latency", cyc - mon_e.gcyc, mon_e.lat);
            first_seen = 1;
          end
          check("rsp_id", rsp_id, mon_e.id);
          check("rsp_addr", rsp_addr, mon_e.addr);
          check("rsp_hit", rsp_hit, mon_e.hit);
          check("rsp_err", rsp_err, mon_e.err);
          if (rsp_ready) begin
            check("wen_pulses", wen_cnt, mon_e.nwen);
            check("ren_pulses", ren_cnt, mon_e.nren);
            void'(expq.pop_front());
            first_seen = 0;
          end
        end
      end
    end
  end

  task automatic wait_grant(output int waited);
    bit got;
    bit pb;
    got = 0;
    waited = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (a_ready || b_ready) begin
        got = 1;
        waited = n;
        pb = b_valid && (!a_valid || m_rr);
        check("grant_sel", {a_ready, b_ready}, {!pb, pb});
        check("full", full, m_full());
        if (a_valid && b_valid) m_rr = !pb;
        if (pb) predict(1'b1, b_op, b_key); else predict(1'b0, a_op, a_key);
        @(posedge clk); #1;
        if (pb) b_valid = 1'b0; else a_valid = 1'b0;
      end
    end
    check("grant_wait", {31'b0, got}, 1);
    if (!got) begin a_valid = 1'b0; b_valid = 1'b0; end
  endtask

  task automatic serve();
    int n;
    while (a_valid || b_valid) wait_grant(n);
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && expq.size() != 0; n++) @(negedge clk);
    check("drain", expq.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    expq.delete();
    for (int i = 0; i < 16; i++) begin m_valid[i] = 1'b0; m_key[i] = '0; end
    m_victim = 0;
    m_rr = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_rsp", {rsp_valid, rsp_id, rsp_addr, rsp_hit, rsp_err}, 0);
    check("rst_ready", {a_ready, b_ready}, 0);
    check("rst_ren_full", {cam_ren, full}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("scrub_wen", cam_wen, 1);
      check("scrub_addr", cam_addr, k);
      check("scrub_din", cam_din, 8'hFF);
      check("scrub_ready", {a_ready, b_ready}, 0);
    end
  endtask

  function automatic logic [7:0] rkey();
    if ($urandom_range(0, 9) == 0) return 8'hFF;
    return 8'(8'h20 + $urandom_range(0, 5));
  endfunction

  initial begin
    int n;
    // Both requesters pending through reset: A wins first, then B.
    a_valid = 1; a_op = 1; a_key = 8'h3C;
    b_valid = 1; b_op = 0; b_key = 8'h3C;
    do_reset();
    wait_grant(n);
    check("first_grant_cycle17", n, 0);
    serve();
    // Second contested pair: pointer now favours B.
    a_valid = 1; a_op = 0; a_key = 8'h55;
    b_valid = 1; b_op = 1; b_key = 8'h3C;
    serve();
    a_valid = 1; a_op = 1; a_key = 8'h3C;
    serve();

    // Reserved key, then a stalled response with B pending.
    drain();
    rdy_mode = 2;
    a_valid = 1; a_op = 0; a_key = 8'hFF;
    serve();
    b_valid = 1; b_op = 0; b_key = 8'h3C;
    repeat (6) @(posedge clk);
    #1 rdy_mode = 0;
    serve();

    // Randomized traffic with random backpressure.
    rdy_mode = 1;
    repeat (120) begin
      int r;
      r = $urandom_range(0, 2);
      a_valid = (r != 1); a_op = 1'($urandom_range(0, 1)); a_key = rkey();
      b_valid = (r != 0); b_op = 1'($urandom_range(0, 1)); b_key = rkey();
      serve();
    end

    // Reset in the middle of an insert drops it and rescrubs.
    drain();
    rdy_mode = 0;
    a_valid = 1; a_op = 1; a_key = 8'h77;
    wait_grant(n);
    do_reset();

    // Fill, then replacement through the victim pointer.
    for (int k = 1; k <= 16; k++) begin
      a_valid = 1; a_op = 1; a_key = 8'(k);
      serve();
    end
    drain();
    check("full_after_fill", full, 1);
    a_valid = 1; a_op = 1; a_key = 8'h11; serve();
    a_valid = 1; a_op = 0; a_key = 8'h01; serve();
    b_valid = 1; b_op = 0; b_key = 8'h11; serve();
    b_valid = 1; b_op = 1; b_key = 8'h12; serve();
    drain();

    for (int i = 0; i < 16; i++)
      check("cam_contents", cmem[i], m_valid[i] ? m_key[i] : 8'hFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
